// File: rtl/top_add_sub_new.sv
// top_add_sub_new: pipelined IEEE-754 binary32 adder/subtracter.
// Stages: input register -> align/add -> normalize/round/pack (latency 3).
// Denormal inputs are treated as signed zero; results too small for a
// normal exponent are flushed to signed zero.
// Defining ADDSUB_OUTPUT_REG_EN adds an output register stage (latency 4).

module top_add_sub_new (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        Sx,
  input  logic [7:0]  Ex,
  input  logic [22:0] Mx,
  input  logic        Sy,
  input  logic [7:0]  Ey,
  input  logic [22:0] My,
  input  logic        sub,
  input  logic [1:0]  roundMode,
  output logic        Sz,
  output logic [7:0]  Ez,
  output logic [22:0] Mz_final,
  output logic        invalid_flag,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        inexact_flag,
  output logic        zero_flag
);

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } round_mode_e;

  typedef struct packed {
    logic        sx;
    logic [7:0]  ex;
    logic [22:0] mx;
    logic        sy;
    logic [7:0]  ey;
    logic [22:0] my;
    logic        sub;
    round_mode_e rm;
  } operands_t;

  // Aligned sum: bit 27 carry, bit 26 hidden, [25:3] fraction, [2:0] guard/round/sticky.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;
    round_mode_e rm;
    logic        invalid;
    logic        inf;
    logic        inf_sign;
    logic        zero_sign;
  } aligned_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        invalid;
    logic        overflow;
    logic        underflow;
    logic        inexact;
    logic        zero;
  } result_t;

  // Leading-zero count of a 27-bit value (27 when the value is zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  operands_t s1_q;
  aligned_t  s2_d, s2_q;
  result_t   s3_d, s3_q;

  // Stage 1: register the raw operands and controls.
  // NOTE: registers use non-blocking assignments so every stage samples the previous stage's old value on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
    end else if (enable) begin
      s1_q <= {Sx, Ex, Mx, Sy, Ey, My, sub, round_mode_e'(roundMode)};
    end
  end

  logic        sy_eff, eff_sub;
  logic        x_zero, y_zero, x_nan, y_nan, x_inf, y_inf, x_big;
  logic [30:0] key_x, key_y;
  logic [23:0] sig_x, sig_y, big_sig, sml_sig;
  logic [7:0]  big_e, sml_e, shift;
  logic [26:0] sml_ext, shifted, al;
  logic        lost;

  // Stage 2 logic: classify, order by magnitude, align the smaller operand, add/subtract.
  // NOTE: every combinationally written signal gets a value on all paths so no latch is inferred.
  always_comb begin
    s2_d    = '0;
    sy_eff  = s1_q.sy ^ s1_q.sub;
    eff_sub = s1_q.sx ^ sy_eff;
    x_zero  = (s1_q.ex == 8'h00);
    y_zero  = (s1_q.ey == 8'h00);
    x_nan   = (s1_q.ex == 8'hFF) && (s1_q.mx != 23'd0);
    y_nan   = (s1_q.ey == 8'hFF) && (s1_q.my != 23'd0);
    x_inf   = (s1_q.ex == 8'hFF) && (s1_q.mx == 23'd0);
    y_inf   = (s1_q.ey == 8'hFF) && (s1_q.my == 23'd0);

    // Denormals compare and add as zero.
    key_x = x_zero ? 31'd0 : {s1_q.ex, s1_q.mx};
    key_y = y_zero ? 31'd0 : {s1_q.ey, s1_q.my};
    sig_x = x_zero ? 24'd0 : {1'b1, s1_q.mx};
    sig_y = y_zero ? 24'd0 : {1'b1, s1_q.my};
    x_big = (key_x >= key_y);

    big_sig = x_big ? sig_x : sig_y;
    sml_sig = x_big ? sig_y : sig_x;
    big_e   = x_big ? s1_q.ex : s1_q.ey;
    sml_e   = x_big ? s1_q.ey : s1_q.ex;
    shift   = big_e - sml_e;

    // Right shift with everything below the round bit folded into sticky.
    sml_ext = {sml_sig, 3'b000};
    shifted = sml_ext >> shift;
    lost    = |(sml_ext & ((27'd1 << shift) - 27'd1));
    if (shift >= 8'd26) al = {26'd0, |sml_sig};
    else                al = {shifted[26:1], shifted[0] | lost};

    s2_d.sign = x_big ? s1_q.sx : sy_eff;
    s2_d.exp  = big_e;
    s2_d.sum  = eff_sub ? ({1'b0, big_sig, 3'b000} - {1'b0, al})
                        : ({1'b0, big_sig, 3'b000} + {1'b0, al});
    s2_d.rm        = s1_q.rm;
    s2_d.invalid   = x_nan | y_nan | (x_inf & y_inf & eff_sub);
    s2_d.inf       = x_inf | y_inf;
    s2_d.inf_sign  = x_inf ? s1_q.sx : sy_eff;
    // Same-signed zeros keep their sign; any other exact zero follows the rounding direction.
    s2_d.zero_sign = (x_zero & y_zero & ~eff_sub) ? s1_q.sx : (s1_q.rm == RM_RDN);
  end

  // Stage 2 register: aligned sum and special-case decisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_q <= '0;
    end else if (enable) begin
      s2_q <= s2_d;
    end
  end

  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_n, exp_f;
  logic              inc, grs;
  logic [24:0]       mant_r;

  // Stage 3 logic: normalize, round, detect overflow/underflow and pack.
  always_comb begin
    s3_d = '0;
    lz   = lzc27(s2_q.sum[26:0]);
    if (s2_q.sum[27]) begin
      norm  = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
      exp_n = signed'({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
      norm  = s2_q.sum[26:0] << lz;
      exp_n = signed'({2'b00, s2_q.exp}) - signed'({5'b00000, lz});
    end

    grs = |norm[2:0];
    case (s2_q.rm)
      RM_RNE:  inc = norm[2] & (norm[1] | norm[0] | norm[3]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~s2_q.sign & grs;
      default: inc = s2_q.sign & grs;
    endcase

    mant_r = {1'b0, norm[26:3]} + {24'd0, inc};
    exp_f  = exp_n + (mant_r[24] ? 10'sd1 : 10'sd0);

    if (s2_q.invalid) begin
      s3_d.exp     = 8'hFF;
      s3_d.frac    = 23'h400000;
      s3_d.invalid = 1'b1;
    end else if (s2_q.inf) begin
      s3_d.sign = s2_q.inf_sign;
      s3_d.exp  = 8'hFF;
    end else if (s2_q.sum == 28'd0) begin
      s3_d.sign = s2_q.zero_sign;
      s3_d.zero = 1'b1;
    end else if (exp_f >= 10'sd255) begin
      s3_d.sign     = s2_q.sign;
      s3_d.overflow = 1'b1;
      s3_d.inexact  = 1'b1;
      if ((s2_q.rm == RM_RNE) || (s2_q.rm == RM_RUP && !s2_q.sign) ||
          (s2_q.rm == RM_RDN && s2_q.sign)) begin
        s3_d.exp = 8'hFF;
      end else begin
        s3_d.exp  = 8'hFE;
        s3_d.frac = 23'h7FFFFF;
      end
    end else if (exp_f < 10'sd1) begin
      s3_d.sign      = s2_q.sign;
      s3_d.underflow = 1'b1;
      s3_d.inexact   = 1'b1;
      s3_d.zero      = 1'b1;
    end else begin
      s3_d.sign    = s2_q.sign;
      s3_d.exp     = exp_f[7:0];
      s3_d.frac    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      s3_d.inexact = grs;
    end
  end

  // Stage 3 register: packed result and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_q <= '0;
    end else if (enable) begin
      s3_q <= s3_d;
    end
  end

`ifdef ADDSUB_OUTPUT_REG_EN
  result_t s4_q;

  // Optional output stage: one more enabled register after round/pack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s4_q <= '0;
    end else if (enable) begin
      s4_q <= s3_q;
    end
  end

  assign {Sz, Ez, Mz_final, invalid_flag, overflow_flag, underflow_flag,
          inexact_flag, zero_flag} = s4_q;
`else
  assign {Sz, Ez, Mz_final, invalid_flag, overflow_flag, underflow_flag,
          inexact_flag, zero_flag} = s3_q;
`endif

endmodule

// File: tb/tb_top_add_sub_new.sv
// tb_top_add_sub_new: directed vectors for top_add_sub_new. Operands and
// results are written as binary32 words; flags as {invalid, overflow,
// underflow, inexact, zero}. A delay line of expected values follows the
// enable signal so stalls and reset discards are tracked.

module tb_top_add_sub_new;

`ifdef ADDSUB_OUTPUT_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic        Sx, Sy, sub;
  logic [7:0]  Ex, Ey;
  logic [22:0] Mx, My;
  logic [1:0]  roundMode;
  logic        Sz;
  logic [7:0]  Ez;
  logic [22:0] Mz_final;
  logic        invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag;
  logic [36:0] out_w;

  int n_vec = 0;
  int n_err = 0;

  logic [36:0] pipe_e [LAT];
  bit          pipe_v [LAT];
  string       pipe_t [LAT];

  top_add_sub_new dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .Sx            (Sx),
    .Ex            (Ex),
    .Mx            (Mx),
    .Sy            (Sy),
    .Ey            (Ey),
    .My            (My),
    .sub           (sub),
    .roundMode     (roundMode),
    .Sz            (Sz),
    .Ez            (Ez),
    .Mz_final      (Mz_final),
    .invalid_flag  (invalid_flag),
    .overflow_flag (overflow_flag),
    .underflow_flag(underflow_flag),
    .inexact_flag  (inexact_flag),
    .zero_flag     (zero_flag)
  );

  assign out_w = {Sz, Ez, Mz_final, invalid_flag, overflow_flag, underflow_flag,
                  inexact_flag, zero_flag};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got word=%08h flags=%05b, expected word=%08h flags=%05b",
               tag, got[36:5], got[4:0], exp[36:5], exp[4:0]);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_e[i] = '0;
      pipe_t[i] = "";
    end
  endtask

  // Drive one operation at the falling edge, clock it in, then check whatever
  // result is due at the output.
  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                    input logic sb, input logic [1:0] rm, input logic en,
                    input logic [31:0] z, input logic [4:0] fl);
    Sx = x[31]; Ex = x[30:23]; Mx = x[22:0];
    Sy = y[31]; Ey = y[30:23]; My = y[22:0];
    sub = sb; roundMode = rm; enable = en;
    @(posedge clk);
    if (en) begin
      for (int i = LAT - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_e[i] = pipe_e[i-1];
        pipe_t[i] = pipe_t[i-1];
      end
      pipe_v[0] = 1'b1;
      pipe_e[0] = {z, fl};
      pipe_t[0] = tag;
    end
    @(negedge clk);
    if (pipe_v[LAT-1]) check(pipe_t[LAT-1], out_w, pipe_e[LAT-1]);
  endtask

  initial begin
    clear_pipe();
    rst = 1'b0;
    enable = 1'b1;
    Sx = 1'b0; Ex = 8'h7F; Mx = 23'd0;
    Sy = 1'b0; Ey = 8'h7F; My = 23'd0;
    sub = 1'b0; roundMode = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", out_w, 37'd0);
    rst = 1'b1;

    op("req027_cancel",  32'h78700000, 32'h78700000, 1'b1, 2'b00, 1'b1, 32'h00000000, 5'b00001);
    op("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 1'b1, 32'h40000000, 5'b00000);
    op("max_ovf_rne",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 1'b1, 32'h7F800000, 5'b01010);
    op("max_ovf_rtz",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 1'b1, 32'h7F7FFFFF, 5'b01010);
    op("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 1'b1, 32'h7FC00000, 5'b10000);
    op("tiny_rne",       32'h3F800000, 32'h33800000, 1'b0, 2'b00, 1'b1, 32'h3F800000, 5'b00010);
    op("tiny_rup",       32'h3F800000, 32'h33800000, 1'b0, 2'b10, 1'b1, 32'h3F800001, 5'b00010);
    // Two stalled cycles with different inputs on the bus: nothing may be captured.
    op("stall_a",        32'h7F800001, 32'h3F800000, 1'b0, 2'b00, 1'b0, 32'h0, 5'b0);
    op("stall_b",        32'hFF7FFFFF, 32'h40000000, 1'b1, 2'b11, 1'b0, 32'h0, 5'b0);
    op("cancel_lzc",     32'h3FC00000, 32'h3FA00000, 1'b1, 2'b00, 1'b1, 32'h3E800000, 5'b00000);
    op("y_bigger",       32'h3F800000, 32'h40000000, 1'b1, 2'b00, 1'b1, 32'hBF800000, 5'b00000);
    op("inf_pass",       32'h7F800000, 32'h3F800000, 1'b0, 2'b00, 1'b1, 32'h7F800000, 5'b00000);
    op("minus_inf",      32'h3F800000, 32'h7F800000, 1'b1, 2'b00, 1'b1, 32'hFF800000, 5'b00000);
    op("nan_in",         32'h7F800001, 32'h3F800000, 1'b0, 2'b00, 1'b1, 32'h7FC00000, 5'b10000);
    op("zero_rdn",       32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 1'b1, 32'h80000000, 5'b00001);
    op("neg_zeros",      32'h80000000, 32'h80000000, 1'b0, 2'b00, 1'b1, 32'h80000000, 5'b00001);
    op("denorm_flush",   32'h00000005, 32'h3F800000, 1'b0, 2'b00, 1'b1, 32'h3F800000, 5'b00000);
    op("underflow",      32'h00C00000, 32'h00800000, 1'b1, 2'b00, 1'b1, 32'h00000000, 5'b00111);
    op("neg_ovf_rup",    32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b10, 1'b1, 32'hFF7FFFFF, 5'b01010);
    op("neg_tiny_rdn",   32'hBF800000, 32'h33800000, 1'b1, 2'b11, 1'b1, 32'hBF800001, 5'b00010);
    op("far_sticky_rup", 32'h3F800000, 32'h28000000, 1'b0, 2'b10, 1'b1, 32'h3F800001, 5'b00010);
    op("rne_tie_odd",    32'h3F800001, 32'h33800000, 1'b0, 2'b00, 1'b1, 32'h3F800002, 5'b00010);
    op("sub_exact",      32'h3F800000, 32'h33800000, 1'b1, 2'b00, 1'b1, 32'h3F7FFFFF, 5'b00000);
    op("lost_a",         32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 1'b1, 32'h7F800000, 5'b01010);
    op("lost_b",         32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 1'b1, 32'h40000000, 5'b00000);

    // Reset mid-stream: outputs clear without a clock edge, in-flight work is dropped.
    rst = 1'b0;
    #1;
    check("reset_async", out_w, 37'd0);
    clear_pipe();
    @(posedge clk);
    @(negedge clk);
    check("reset_held", out_w, 37'd0);
    rst = 1'b1;

    op("post_rst",       32'h3FC00000, 32'h3FA00000, 1'b0, 2'b00, 1'b1, 32'h40300000, 5'b00000);
    for (int i = 0; i < LAT; i++) begin
      op("drain_zero",   32'h00000000, 32'h00000000, 1'b0, 2'b00, 1'b1, 32'h00000000, 5'b00001);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
